// File: rtl/dlfloat_dot_seq_if.sv
// Stream and result handshake bundle for the DLfloat16 dot-product sequencer.
//   start/len      command from the requester (len latched with start)
//   busy           sequencer is not idle
//   in_valid/in_ready/in_a/in_b    operand-pair stream
//   res_valid/res_ready/res_data   dot-product result
// master: requester / operand source / result consumer
// slave : the sequencer
interface dlfloat_dot_seq_if #(
   parameter int LEN_W = 8
);
   logic             start;
   logic [LEN_W-1:0] len;
   logic             busy;
   logic             in_valid;
   logic             in_ready;
   logic [15:0]      in_a;
   logic [15:0]      in_b;
   logic             res_valid;
   logic             res_ready;
   logic [15:0]      res_data;

   modport master (
      output start, len, in_valid, in_a, in_b, res_ready,
      input  busy, in_ready, res_valid, res_data
   );

   modport slave (
      input  start, len, in_valid, in_a, in_b, res_ready,
      output busy, in_ready, res_valid, res_data
   );
endinterface

// File: rtl/dlfloat_dot_seq.sv
// Sequences a DLfloat16 MAC (1s/6e/9m, bias 31) through one dot product
// sum(a_i*b_i), i=0..len-1: clears the accumulator, streams operand pairs
// (zero bubbles when no pair is present), drains the MAC pipeline and
// returns the accumulator value on the result handshake.
// Ports:
//   clk, rst_n     clock and synchronous active-low reset
//   bus            dlfloat_dot_seq_if.slave (command, operand stream, result)
//   mac_clr_n      MAC reset; low clears its operands and accumulator
//   mac_a, mac_b   registered MAC operands
//   mac_c          MAC accumulator output
//
// state  | meaning
// IDLE   | waiting for start; MAC fed 0*0 bubbles, accumulator untouched
// CLEAR  | mac_clr_n held low for CLR_CYC cycles
// STREAM | accepting operand pairs, bubbles on idle cycles
// DRAIN  | zero operands for MAC_LAT cycles, then capture mac_c
// DONE   | result presented until res_valid & res_ready
module dlfloat_dot_seq #(
   parameter int LEN_W   = 8,
   parameter int MAC_LAT = 4,
   parameter int CLR_CYC = MAC_LAT + 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   dlfloat_dot_seq_if.slave        bus,
   output logic                    mac_clr_n,
   output logic [15:0]             mac_a,
   output logic [15:0]             mac_b,
   input  logic [15:0]             mac_c
);

   localparam int TMAX = (CLR_CYC > MAC_LAT) ? CLR_CYC : MAC_LAT;
   localparam int TW   = $clog2(TMAX) + 1;
   localparam logic [TW-1:0] CLR_LOAD = TW'(CLR_CYC - 1);
   localparam logic [TW-1:0] LAT_LOAD = TW'(MAC_LAT - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CLEAR  = 3'd1,
      STREAM = 3'd2,
      DRAIN  = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t           state;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] cnt;
   logic [TW-1:0]    tmr;
   logic             in_ready_q;
   logic             res_valid_q;
   logic [15:0]      res_data_q;
   logic             busy_q;

   assign bus.in_ready  = in_ready_q;
   assign bus.res_valid = res_valid_q;
   assign bus.res_data  = res_data_q;
   assign bus.busy      = busy_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         len_q       <= '0;
         cnt         <= '0;
         tmr         <= '0;
         mac_clr_n   <= 1'b0;
         mac_a       <= 16'h0000;
         mac_b       <= 16'h0000;
         in_ready_q  <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= 16'h0000;
         busy_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               mac_clr_n <= 1'b1;
               mac_a     <= 16'h0000;
               mac_b     <= 16'h0000;
               cnt       <= '0;
               if (bus.start) begin
                  busy_q <= 1'b1;
                  if (bus.len != '0) begin
                     len_q     <= bus.len;
                     tmr       <= CLR_LOAD;
                     mac_clr_n <= 1'b0;
                     state     <= CLEAR;
                  end else begin
                     // empty product: answer zero without touching the MAC
                     res_data_q  <= 16'h0000;
                     res_valid_q <= 1'b1;
                     state       <= DONE;
                  end
               end
            end

            CLEAR: begin
               mac_a <= 16'h0000;
               mac_b <= 16'h0000;
               if (tmr == '0) begin
                  mac_clr_n  <= 1'b1;
                  in_ready_q <= 1'b1;
                  state      <= STREAM;
               end else begin
                  tmr <= tmr - TW'(1);
               end
            end

            STREAM: begin
               if (bus.in_valid && in_ready_q) begin
                  mac_a <= bus.in_a;
                  mac_b <= bus.in_b;
                  cnt   <= cnt + LEN_W'(1);
                  if (cnt == len_q - LEN_W'(1)) begin
                     in_ready_q <= 1'b0;
                     tmr        <= LAT_LOAD;
                     state      <= DRAIN;
                  end
               end else begin
                  mac_a <= 16'h0000;
                  mac_b <= 16'h0000;
               end
            end

            DRAIN: begin
               mac_a <= 16'h0000;
               mac_b <= 16'h0000;
               if (tmr == '0) begin
                  res_data_q  <= mac_c;
                  res_valid_q <= 1'b1;
                  state       <= DONE;
               end else begin
                  tmr <= tmr - TW'(1);
               end
            end

            DONE: begin
               mac_a <= 16'h0000;
               mac_b <= 16'h0000;
               if (bus.res_ready) begin
                  res_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state       <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dlfloat_dot_seq.sv
module tb_dlfloat_dot_seq;

   localparam int LEN_W   = 8;
   localparam int MAC_LAT = 4;
   localparam int CLR_CYC = MAC_LAT + 1;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mac_clr_n;
   logic [15:0] mac_a, mac_b, mac_c;

   int checks = 0;
   int errors = 0;

   dlfloat_dot_seq_if #(.LEN_W(LEN_W)) bus ();

   dlfloat_dot_seq #(.LEN_W(LEN_W), .MAC_LAT(MAC_LAT), .CLR_CYC(CLR_CYC)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .mac_clr_n (mac_clr_n),
      .mac_a     (mac_a),
      .mac_b     (mac_b),
      .mac_c     (mac_c)
   );

   always #5 clk = ~clk;

   // Behavioural MAC: product registered twice, then accumulated, so the
   // accumulator reflects an operand change on the fourth edge counting the
   // edge at which the operand register changed.
   function automatic real dl_dec(input logic [15:0] x);
      int  e;
      real v;
      e = int'(x[14:9]);
      if (e == 0 && x[8:0] == 9'd0) return 0.0;
      v = (1.0 + real'(x[8:0]) / 512.0) * (2.0 ** real'(e - 31));
      return x[15] ? -v : v;
   endfunction

   function automatic logic [15:0] dl_enc(input real r);
      real v;
      int  e;
      logic s;
      if (r == 0.0) return 16'h0000;
      s = (r < 0.0);
      v = s ? -r : r;
      e = 31;
      while (v >= 2.0) begin v = v / 2.0; e++; end
      while (v < 1.0)  begin v = v * 2.0; e--; end
      return {s, 6'(e), 9'(int'($floor((v - 1.0) * 512.0)))};
   endfunction

   real p0, p1, acc;
   always @(posedge clk) begin
      if (!mac_clr_n) begin
         p0  <= 0.0;
         p1  <= 0.0;
         acc <= 0.0;
      end else begin
         p0  <= dl_dec(mac_a) * dl_dec(mac_b);
         p1  <= p0;
         acc <= acc + p1;
      end
   end
   always_comb mac_c = dl_enc(acc);

   typedef struct {
      int               len;
      logic [3:0][15:0] a;
      logic [3:0][15:0] b;
      logic [3:0][3:0]  gap;
      logic [15:0]      exp_res;
      int               exp_lat;
      int               hold;
      string            name;
   } vec_t;

   vec_t vt[6];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, req);
      end
   endtask

   task automatic run_vec(input int v);
      int   cyc, idx, gap_left;
      logic beat, was_ready, done;
      bus.start = 1'b1;
      bus.len   = LEN_W'(vt[v].len);
      @(posedge clk); #1;
      bus.start = 1'b0;
      cyc = 0; idx = 0; done = 1'b0;
      gap_left = int'(vt[v].gap[0]);
      while (!done) begin
         if (idx < vt[v].len && gap_left == 0) begin
            bus.in_valid = 1'b1;
            bus.in_a = vt[v].a[idx];
            bus.in_b = vt[v].b[idx];
         end else begin
            bus.in_valid = 1'b0;
            bus.in_a = 16'h7777;
            bus.in_b = 16'h7777;
         end
         was_ready = bus.in_ready;
         beat = bus.in_valid & bus.in_ready;
         @(posedge clk); #1;
         cyc++;
         if (beat) begin
            idx++;
            gap_left = (idx < 4) ? int'(vt[v].gap[idx]) : 0;
         end else if (was_ready) begin
            if (gap_left > 0) gap_left--;
            chk({vt[v].name, " bubble"}, {32'h0, mac_a, mac_b}, 64'h0);
         end
         if (bus.res_valid) done = 1'b1;
         if (cyc > 200) begin
            checks++; errors++;
            $display("FAIL %s timeout: res_valid not seen after %0d cycles", vt[v].name, cyc);
            done = 1'b1;
         end
      end
      bus.in_valid = 1'b0;
      chk({vt[v].name, " res_data"}, 64'(bus.res_data), 64'(vt[v].exp_res));
      chk({vt[v].name, " latency"}, 64'(cyc), 64'(vt[v].exp_lat));
      for (int h = 0; h < vt[v].hold; h++) begin
         bus.start = 1'b1;
         bus.len   = 8'd2;
         @(posedge clk); #1;
         chk({vt[v].name, " hold"}, {47'h0, bus.res_valid, bus.res_data},
             {47'h0, 1'b1, vt[v].exp_res});
      end
      bus.start = 1'b0;
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      bus.res_ready = 1'b0;
      chk({vt[v].name, " idle after handshake"}, {62'h0, bus.res_valid, bus.busy}, 64'h0);
   endtask

   logic ready_seen;

   initial begin
      vt[0] = '{len:3, a:{16'h0, 16'h3E00, 16'h3E00, 16'h3E00}, b:{16'h0, 16'h3E00, 16'h3E00, 16'h3E00},
                gap:16'h0000, exp_res:16'h4100, exp_lat:CLR_CYC+3+MAC_LAT, hold:0, name:"len3_ones"};
      vt[1] = '{len:2, a:{16'h0, 16'h0, 16'h3C00, 16'h4000}, b:{16'h0, 16'h0, 16'h4000, 16'h4000},
                gap:{4'd0, 4'd0, 4'd2, 4'd0}, exp_res:16'h4280, exp_lat:CLR_CYC+2+MAC_LAT+2, hold:0,
                name:"len2_gaps"};
      vt[2] = '{len:1, a:{16'h0, 16'h0, 16'h0, 16'h4000}, b:{16'h0, 16'h0, 16'h0, 16'h3E00},
                gap:16'h0000, exp_res:16'h4000, exp_lat:CLR_CYC+1+MAC_LAT, hold:0, name:"b2b_first"};
      vt[3] = '{len:1, a:{16'h0, 16'h0, 16'h0, 16'h3E00}, b:{16'h0, 16'h0, 16'h0, 16'h3E00},
                gap:16'h0000, exp_res:16'h3E00, exp_lat:CLR_CYC+1+MAC_LAT, hold:0, name:"b2b_second"};
      vt[4] = '{len:4, a:{16'h3E00, 16'h3E00, 16'h3E00, 16'h3E00}, b:{16'h4000, 16'h4000, 16'h4000, 16'h4000},
                gap:{4'd0, 4'd1, 4'd0, 4'd1}, exp_res:16'h4400, exp_lat:CLR_CYC+4+MAC_LAT+2, hold:0,
                name:"len4_gaps"};
      vt[5] = '{len:1, a:{16'h0, 16'h0, 16'h0, 16'h4000}, b:{16'h0, 16'h0, 16'h0, 16'h4000},
                gap:16'h0000, exp_res:16'h4200, exp_lat:CLR_CYC+1+MAC_LAT, hold:10, name:"done_hold"};

      rst_n = 1'b0;
      bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0;
      bus.in_a = 16'h0; bus.in_b = 16'h0; bus.res_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset outputs",
          {21'h0, mac_a, mac_b, mac_clr_n, bus.res_valid, bus.res_data, bus.in_ready, bus.busy},
          64'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle mac_clr_n", 64'(mac_clr_n), 64'h1);

      for (int v = 0; v < 6; v++) run_vec(v);
      @(posedge clk); #1;
      chk("start while busy not queued", 64'(bus.busy), 64'h0);

      // len==0: immediate zero result, no CLEAR, no streaming
      ready_seen = 1'b0;
      bus.start = 1'b1; bus.len = '0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      ready_seen |= bus.in_ready;
      chk("len0 result", {46'h0, bus.res_valid, bus.busy, bus.res_data}, {46'h0, 1'b1, 1'b1, 16'h0000});
      chk("len0 no clear", 64'(mac_clr_n), 64'h1);
      @(posedge clk); #1;
      ready_seen |= bus.in_ready;
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      bus.res_ready = 1'b0;
      ready_seen |= bus.in_ready;
      chk("len0 in_ready never high", 64'(ready_seen), 64'h0);
      chk("len0 idle", {62'h0, bus.res_valid, bus.busy}, 64'h0);

      // reset in the middle of a stream aborts the run
      bus.start = 1'b1; bus.len = 8'd3;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int k = 0; k < 20 && !bus.in_ready; k++) begin
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b1; bus.in_a = 16'h4000; bus.in_b = 16'h4000;
      @(posedge clk); #1;
      chk("mid-stream operand", {32'h0, mac_a, mac_b}, {32'h0, 16'h4000, 16'h4000});
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("abort reset outputs",
          {21'h0, mac_a, mac_b, mac_clr_n, bus.res_valid, bus.res_data, bus.in_ready, bus.busy},
          64'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_vec(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
